// File: rtl/sd_wr_axi_burst.sv
// Packs the SD halfword stream into DATA_WIDTH beats, buffers them, and writes
// them to DDR as INCR AXI bursts from a programmable base address.
module sd_wr_axi_burst #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8,
  parameter int ID_VALUE   = 0,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] wr_base_addr,
  input  logic                  wr_en,
  input  logic [15:0]           wrdata,
  input  logic                  wrlast,
  output logic [ID_WIDTH-1:0]   model_awid,
  output logic [ADDR_WIDTH-1:0] model_awaddr,
  output logic [7:0]            model_awlen,
  output logic [2:0]            model_awsize,
  output logic [1:0]            model_awburst,
  output logic                  model_awlock,
  output logic [3:0]            model_awcache,
  output logic [2:0]            model_awprot,
  output logic                  model_awvalid,
  input  logic                  model_awready,
  output logic [DATA_WIDTH-1:0] model_wdata,
  output logic [STRB_WIDTH-1:0] model_wstrb,
  output logic                  model_wlast,
  output logic                  model_wvalid,
  input  logic                  model_wready,
  input  logic [ID_WIDTH-1:0]   model_bid,
  input  logic [1:0]            model_bresp,
  input  logic                  model_bvalid,
  output logic                  model_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  resp_err
);

  localparam int NHW  = DATA_WIDTH/16;
  localparam int HW_W = (NHW > 1) ? $clog2(NHW) : 1;
  localparam int SBW  = HW_W + 2;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = $clog2(BURST_LEN+1);
  localparam int EW   = STRB_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_FIN} state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] base_addr, burst_offset, awaddr_q;
  logic [LW-1:0]         len_q, beat_cnt, burst_len_nx;
  logic                  burst_go, b_hs;

  // ---------------- packer ----------------
  logic [HW_W-1:0]       hw_idx;
  logic [DATA_WIDTH-1:0] beat_q, push_data;
  logic [STRB_WIDTH-1:0] push_strb;
  logic [SBW-1:0]        strb_bytes;
  logic                  last_seen, hw_acc, push_req;

  assign hw_acc     = wr_en && busy && !last_seen && !start;
  assign push_req   = hw_acc && (wrlast || hw_idx == HW_W'(NHW-1));
  assign strb_bytes = ({2'b00, hw_idx} + SBW'(1)) << 1;

  // Slots above hw_idx are still zero in beat_q, so a short final beat is zero padded.
  always_comb begin
    push_data = beat_q;
    push_strb = '0;
    for (int k = 0; k < NHW; k++)
      if (hw_idx == HW_W'(k)) push_data[16*k +: 16] = wrdata;
    for (int i = 0; i < STRB_WIDTH; i++)
      push_strb[i] = (SBW'(i) < strb_bytes);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      hw_idx    <= '0;
      beat_q    <= '0;
      last_seen <= 1'b0;
    end else if (hw_acc) begin
      if (push_req) begin
        hw_idx <= '0;
        beat_q <= '0;
        if (wrlast) last_seen <= 1'b1;
      end else begin
        hw_idx <= hw_idx + HW_W'(1);
        beat_q <= push_data;
      end
    end
  end

  // ---------------- beat FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, count;
  logic          full, empty, pop, do_push, ovf_drop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = model_wvalid && model_wready;
  // A pop in the same cycle frees the slot, so a push on a full FIFO is still taken.
  assign do_push  = push_req && (!full || pop);
  assign ovf_drop = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= {push_strb, push_data};
  end

  assign {model_wstrb, model_wdata} = mem[rd_ptr[PW-1:0]];

  // ---------------- burst FSM ----------------
  assign burst_len_nx = (count >= (PW+1)'(BURST_LEN)) ? LW'(BURST_LEN) : count[LW-1:0];

  always_ff @(posedge clk) begin
    if (rst || start) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    model_awvalid = 1'b0;
    model_wvalid  = 1'b0;
    model_wlast   = 1'b0;
    model_bready  = 1'b0;
    done          = 1'b0;
    burst_go      = 1'b0;
    b_hs          = 1'b0;
    case (state)
      S_IDLE: begin
        if (busy && (count >= (PW+1)'(BURST_LEN) || (last_seen && !empty))) begin
          burst_go = 1'b1;
          state_nx = S_AW;
        end else if (busy && last_seen) begin
          state_nx = S_FIN;
        end
      end
      S_AW: begin
        model_awvalid = 1'b1;
        if (model_awready) state_nx = S_W;
      end
      S_W: begin
        model_wvalid = !empty;
        model_wlast  = (beat_cnt == len_q - LW'(1));
        if (pop && model_wlast) state_nx = S_B;
      end
      S_B: begin
        model_bready = 1'b1;
        if (model_bvalid) begin
          b_hs     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) base_addr <= '0;
    else if (start) base_addr <= wr_base_addr;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      busy         <= start && !rst;
      overflow     <= 1'b0;
      resp_err     <= 1'b0;
      burst_offset <= '0;
      awaddr_q     <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
    end else begin
      if (state == S_FIN) busy <= 1'b0;
      if (ovf_drop) overflow <= 1'b1;
      if (burst_go) begin
        len_q    <= burst_len_nx;
        awaddr_q <= base_addr + burst_offset;
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + LW'(1);
      end
      if (b_hs) begin
        resp_err     <= resp_err | (|model_bresp);
        burst_offset <= burst_offset + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(STRB_WIDTH);
      end
    end
  end

  assign model_awid    = ID_WIDTH'(ID_VALUE);
  assign model_awaddr  = awaddr_q;
  assign model_awlen   = 8'(len_q - LW'(1));
  assign model_awsize  = 3'($clog2(STRB_WIDTH));
  assign model_awburst = 2'b01;
  assign model_awlock  = 1'b0;
  assign model_awcache = 4'b0011;
  assign model_awprot  = 3'b000;

  logic unused_bid;
  assign unused_bid = ^model_bid;

endmodule
